// File: rtl/montgomery_modexp_if.sv
// Host-side bundle for the Montgomery modular exponentiation engine:
// operand load, start request, and the busy/done/result status returned to the host.
interface montgomery_modexp_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] exponent;
    logic [DATA_WIDTH-1:0] modulant;
    logic [DATA_WIDTH-1:0] r_mod;
    logic [DATA_WIDTH-1:0] r2_mod;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, base, exponent, modulant, r_mod, r2_mod,
        input  busy, done, result
    );

    modport slave (
        input  start, base, exponent, modulant, r_mod, r2_mod,
        output busy, done, result
    );
endinterface

// File: rtl/montgomery_modexp.sv
// Sequential base^exponent mod n in the Montgomery domain, one REDC per clock,
// together with the combinational montgomery_reduce block that it drives.
module montgomery_reduce #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2*DATA_WIDTH-1:0] t,
    input  logic [DATA_WIDTH-1:0]   modulant,
    input  logic [DATA_WIDTH-1:0]   R_div_two,
    output logic [DATA_WIDTH-1:0]   out
);
    localparam int SW = 2*DATA_WIDTH + 1;

    logic [SW-1:0]       w_sum;
    logic [DATA_WIDTH:0] w_quot;
    logic                w_unusedRDivTwo;

    // Bit-serial REDC: clear the low DATA_WIDTH bits by adding shifted copies of n,
    // so the upper half is t*R^-1 mod n up to one final subtract.
    always_comb begin
        w_sum = {1'b0, t};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_sum[i]) begin
                w_sum = w_sum + (SW'(modulant) << i);
            end
        end
        w_quot = w_sum[SW-1:DATA_WIDTH];
        if (w_quot >= {1'b0, modulant}) begin
            out = DATA_WIDTH'(w_quot - {1'b0, modulant});
        end else begin
            out = DATA_WIDTH'(w_quot);
        end
    end

    assign w_unusedRDivTwo = ^R_div_two;
endmodule

module montgomery_modexp #(
    parameter int DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    montgomery_modexp_if.slave bus
);
    localparam int TW   = 2*DATA_WIDTH;
    localparam int IDXW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] R_DIV_TWO = DATA_WIDTH'(1) << (DATA_WIDTH-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SQ,
        S_MUL,
        S_OUT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_exp;
    logic [DATA_WIDTH-1:0] r_n;
    logic [DATA_WIDTH-1:0] r_r2Mod;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_baseM;
    logic [IDXW-1:0]       r_bitIdx;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;

    logic [DATA_WIDTH-1:0] w_x;
    logic [DATA_WIDTH-1:0] w_y;
    logic [TW-1:0]         w_t;
    logic [DATA_WIDTH-1:0] w_red;

    // Operand selection for the single shared reducer.
    always_comb begin
        w_x = '0;
        w_y = '0;
        case (r_state)
            S_CONV: begin w_x = r_base; w_y = r_r2Mod; end
            S_SQ:   begin w_x = r_acc;  w_y = r_acc;   end
            S_MUL:  begin w_x = r_acc;  w_y = r_baseM; end
            S_OUT:  begin w_x = r_acc;  w_y = DATA_WIDTH'(1); end
            default: begin w_x = '0; w_y = '0; end
        endcase
    end

    assign w_t = TW'(w_x) * TW'(w_y);

    montgomery_reduce #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_reduce (
        .t        (w_t),
        .modulant (r_n),
        .R_div_two(R_DIV_TWO),
        .out      (w_red)
    );

    // Leading exponent zeros are still squared so latency depends only on popcount.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_r2Mod  <= '0;
            r_acc    <= '0;
            r_baseM  <= '0;
            r_bitIdx <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base   <= bus.base;
                        r_exp    <= bus.exponent;
                        r_n      <= bus.modulant;
                        r_r2Mod  <= bus.r2_mod;
                        r_acc    <= bus.r_mod;
                        r_bitIdx <= IDXW'(DATA_WIDTH-1);
                        r_busy   <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_baseM <= w_red;
                    r_state <= S_SQ;
                end
                S_SQ: begin
                    r_acc <= w_red;
                    if (r_exp[r_bitIdx]) begin
                        r_state <= S_MUL;
                    end else if (r_bitIdx == '0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_bitIdx <= r_bitIdx - 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_red;
                    if (r_bitIdx == '0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_bitIdx <= r_bitIdx - 1'b1;
                        r_state  <= S_SQ;
                    end
                end
                S_OUT: begin
                    r_result <= w_red;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_montgomery_modexp.sv
// Directed and randomized checks of montgomery_modexp against a plain
// repeated-multiplication modular exponent model.
module tb_montgomery_modexp;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    montgomery_modexp_if #(.DATA_WIDTH(W)) bus ();

    montgomery_modexp #(.DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int refModExp(input int b, input int e, input int n);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return int'(r % n);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge with start dropped.
    task automatic applyStimulus(input int b, input int e, input int n);
        bus.base     = W'(b);
        bus.exponent = W'(e);
        bus.modulant = W'(n);
        bus.r_mod    = W'(256 % n);
        bus.r2_mod   = W'(65536 % n);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic runCase(input string tag, input int b, input int e, input int n);
        int lat = -1;
        logic [W-1:0] res = '0;
        applyStimulus(b, e, n);
        checkOutput({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = cyc;
                res = bus.result;
                break;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(W + $countones(e) + 2));
        checkOutput({tag, " result"}, 32'(res), 32'(refModExp(b, e, n)));
        if (lat > 0) begin
            checkOutput({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            checkOutput({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
            checkOutput({tag, " done_after_done"}, 32'(bus.done), 32'd0);
            checkOutput({tag, " result_held"}, 32'(bus.result), 32'(refModExp(b, e, n)));
        end
    endtask

    initial begin
        int doneCnt;
        int lat;
        logic [W-1:0] res;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.base = '0; bus.exponent = '0; bus.modulant = '0;
        bus.r_mod = '0; bus.r2_mod = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed cases");
        runCase("n13_b4_e13", 4, 13, 13);
        runCase("n251_b2_e8", 2, 8, 251);
        runCase("n251_b2_e255", 2, 255, 251);
        runCase("n13_b4_e0", 4, 0, 13);
        runCase("n13_b0_e5", 0, 5, 13);
        runCase("n13_b1_e200", 1, 200, 13);
        runCase("n255_b254_e255", 254, 255, 255);

        $display("[TB] start while busy");
        applyStimulus(4, 13, 13);
        doneCnt = 0; lat = -1; res = '0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (cyc == 5) begin
                bus.base = 8'd7; bus.exponent = 8'd200; bus.modulant = 8'd11;
                bus.r_mod = 8'd3; bus.r2_mod = 8'd9;
                bus.start = 1'b1;
            end
            if (cyc == 6) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                doneCnt++;
                lat = cyc;
                res = bus.result;
            end
        end
        checkOutput("busy_start done_count", 32'(doneCnt), 32'd1);
        checkOutput("busy_start latency", 32'(lat), 32'd13);
        checkOutput("busy_start result", 32'(res), 32'd4);
        checkOutput("busy_start idle_after", 32'(bus.busy), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(4, 13, 13);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset done", 32'(bus.done), 32'd0);
        checkOutput("midreset result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) doneCnt++;
        end
        checkOutput("midreset no_done", 32'(doneCnt), 32'd0);
        runCase("after_reset", 4, 13, 13);

        $display("[TB] randomized sweep");
        for (int k = 0; k < 14; k++) begin
            int n, b, e;
            n = int'($urandom_range(1, 127)) * 2 + 1;
            b = int'($urandom_range(0, n - 1));
            e = int'($urandom_range(0, 255));
            runCase($sformatf("rand%0d_n%0d_b%0d_e%0d", k, n, b, e), b, e, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
